// File: rtl/axis_pkg.sv
// Shared definitions for the AXI Stream blocks.
// Holds the default buffer depth and the pointer-width helper.
package axis_pkg;

    localparam int AXIS_BUFFER_DEPTH_DEFAULT = 2;

    function automatic int axis_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI Stream interface bundle (tvalid, tready, tdata).
// Modport m drives the stream, modport s receives it.
interface axis_if #(
    parameter int TDATA_WIDTH = 8
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_buffer_mem.sv
// DEPTH x WIDTH register array with async clear on rst.
// Ports: clk, rst, one write port (we, waddr, wdata), one comb read port
// (raddr, rdata).
module axis_buffer_mem
    import axis_pkg::*;
#(
    parameter int DEPTH = AXIS_BUFFER_DEPTH_DEFAULT,
    parameter int WIDTH = 8,
    localparam int AW   = axis_ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [DEPTH-1:0][WIDTH-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_buffer.sv
// Depth-configurable AXI Stream buffer with selectable ready mode and flush.
// Ports: clk, rst (async, active high), axis_sif (input stream, modport s),
// axis_mif (output stream, modport m), flush (sync discard of stored beats),
// level (occupancy, only when AXIS_BUFFER_LEVEL_EN is defined).
module axis_buffer
    import axis_pkg::*;
#(
    parameter int DEPTH      = AXIS_BUFFER_DEPTH_DEFAULT,
    parameter int READY_PASS = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_if.m                          axis_mif,
    axis_if.s                          axis_sif,
    input  logic                       flush
`ifdef AXIS_BUFFER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    localparam int TDATA_WIDTH = axis_mif.TDATA_WIDTH;
    localparam int PW          = axis_ptr_width(DEPTH);
    localparam int CW          = $clog2(DEPTH + 1);
    localparam bit PASS        = (READY_PASS != 0);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "axis_buffer: DEPTH must be >= 1");
    end

    if (TDATA_WIDTH == 0 ||
        TDATA_WIDTH != axis_sif.TDATA_WIDTH) begin : g_bad_width
        $fatal(1, "axis_buffer: bad or mismatched TDATA_WIDTH");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic sif_ready;
    logic mif_valid;
    logic push;
    logic pop;

    assign full      = (count_q == FULL_CNT);
    assign mif_valid = (count_q != '0);

    // Flush and reset both hold off the input side so no beat is lost.
    assign sif_ready = !rst && !flush &&
                       (!full || (PASS && axis_mif.tready));

    assign push = axis_sif.tvalid && sif_ready;
    assign pop  = mif_valid && axis_mif.tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0
                         : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0
                         : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When full with push+pop, wr_ptr == rd_ptr: the write lands in the
    // slot being read out this cycle, which is safe with a comb read port.
    axis_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (TDATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (axis_sif.tdata),
        .raddr (rd_ptr_q),
        .rdata (axis_mif.tdata)
    );

    assign axis_mif.tvalid = mif_valid;
    assign axis_sif.tready = sif_ready;

`ifdef AXIS_BUFFER_LEVEL_EN
    assign level = count_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= FULL_CNT &&
                    !(push && !pop && full) &&
                    !(pop && !push && !mif_valid))
            else $error("axis_buffer: count overflow/underflow");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_axis_buffer.sv
// Self-checking bench for axis_buffer across several DEPTH/READY_PASS builds.
// Outputs are compared every cycle with a queue-based reference model.
module tb_axis_buffer;

    localparam int N = 5;
    localparam int DEP [N] = '{4, 3, 1, 1, 2};
    localparam int RP  [N] = '{0, 0, 1, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       s_valid [N];
    logic [7:0] s_data  [N];
    logic       s_ready [N];
    logic       m_valid [N];
    logic [7:0] m_data  [N];
    logic       m_ready [N];
    logic       flush   [N];
`ifdef AXIS_BUFFER_LEVEL_EN
    logic [2:0] lvl     [N];
`endif

    for (genvar g = 0; g < N; g++) begin : g_dut
        axis_if #(.TDATA_WIDTH(8)) sif ();
        axis_if #(.TDATA_WIDTH(8)) mif ();

        assign sif.tvalid = s_valid[g];
        assign sif.tdata  = s_data[g];
        assign s_ready[g] = sif.tready;
        assign m_valid[g] = mif.tvalid;
        assign m_data[g]  = mif.tdata;
        assign mif.tready = m_ready[g];

`ifdef AXIS_BUFFER_LEVEL_EN
        logic [$clog2(DEP[g]+1)-1:0] level;
        assign lvl[g] = 3'(level);
`endif

        axis_buffer #(
            .DEPTH      (DEP[g]),
            .READY_PASS (RP[g])
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .axis_mif (mif.m),
            .axis_sif (sif.s),
            .flush    (flush[g])
`ifdef AXIS_BUFFER_LEVEL_EN
            ,
            .level    (level)
`endif
        );
    end

    logic [7:0] q [N][$];
    int  tests = 0;
    int  fails = 0;
    int  popcnt [N];
    bit  psh [N];
    int  seq1;

    task automatic chk(input string tag, input int g,
                       input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: observed %0h expected %0h",
                   tag, g, obs, exp);
        end
    endtask

    function automatic bit exp_ready(input int g);
        return !rst && !flush[g] &&
               (q[g].size() < DEP[g] || (RP[g] != 0 && m_ready[g]));
    endfunction

    task automatic look();
        #2;
        for (int g = 0; g < N; g++) begin
            if (m_valid[g] === 1'b1 && m_ready[g]) popcnt[g]++;
            chk("tvalid", g, 32'(m_valid[g]), 32'(q[g].size() != 0));
            chk("tready", g, 32'(s_ready[g]), 32'(exp_ready(g)));
            if (q[g].size() != 0)
                chk("tdata", g, 32'(m_data[g]), 32'(q[g][0]));
`ifdef AXIS_BUFFER_LEVEL_EN
            chk("level", g, 32'(lvl[g]), q[g].size());
`endif
        end
    endtask

    task automatic adv();
        bit         pp [N];
        logic [7:0] dl [N];
        for (int g = 0; g < N; g++) begin
            psh[g] = s_valid[g] && exp_ready(g);
            pp[g]  = (q[g].size() != 0) && m_ready[g];
            dl[g]  = s_data[g];
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                q[g].delete();
            end else begin
                if (pp[g]) void'(q[g].pop_front());
                if (flush[g]) q[g].delete();
                else if (psh[g]) q[g].push_back(dl[g]);
            end
        end
    endtask

    task automatic tick();
        look();
        adv();
    endtask

    task automatic chk_rst_outputs(input string tag);
        for (int g = 0; g < N; g++) begin
            chk({tag, "_tvalid"}, g, 32'(m_valid[g]), 0);
            chk({tag, "_tready"}, g, 32'(s_ready[g]), 0);
            chk({tag, "_tdata"}, g, 32'(m_data[g]), 0);
`ifdef AXIS_BUFFER_LEVEL_EN
            chk({tag, "_level"}, g, 32'(lvl[g]), 0);
`endif
        end
    endtask

    logic [7:0] d4 [4];

    initial begin
        d4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int g = 0; g < N; g++) begin
            s_valid[g] = 1'b0;
            s_data[g]  = '0;
            m_ready[g] = 1'b0;
            flush[g]   = 1'b0;
            popcnt[g]  = 0;
            psh[g]     = 1'b0;
        end

        #1 rst = 1'b1;
        #1 chk_rst_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // DEPTH=4, READY_PASS=0: fill with downstream stalled, then drain.
        for (int i = 0; i < 4; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = d4[i];
            tick();
        end
        s_valid[0] = 1'b0;
        look();
        chk("d4_full_tready", 0, 32'(s_ready[0]), 0);
        adv();
        m_ready[0] = 1'b1;
        popcnt[0]  = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("d4_drain_pops", 0, popcnt[0], 4);
        tick();
        m_ready[0] = 1'b0;

        // DEPTH=2, READY_PASS=1: push+pop while full.
        for (int i = 0; i < 2; i++) begin
            s_valid[4] = 1'b1;
            s_data[4]  = (i == 0) ? 8'hAA : 8'hBB;
            tick();
        end
        s_data[4]  = 8'hCC;
        m_ready[4] = 1'b1;
        look();
        chk("full_pp_tready", 4, 32'(s_ready[4]), 1);
        chk("full_pp_data", 4, 32'(m_data[4]), 32'h0AA);
        adv();
        s_valid[4] = 1'b0;
        look();
        chk("full_next_bb", 4, 32'(m_data[4]), 32'h0BB);
        adv();
        look();
        chk("full_next_cc", 4, 32'(m_data[4]), 32'h0CC);
        adv();
        tick();

        // DEPTH=2 flush with a pop in the same cycle.
        m_ready[4] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid[4] = 1'b1;
            s_data[4]  = (i == 0) ? 8'hAA : 8'hBB;
            tick();
        end
        s_data[4]  = 8'hDD;
        flush[4]   = 1'b1;
        m_ready[4] = 1'b1;
        look();
        chk("flush_tready", 4, 32'(s_ready[4]), 0);
        chk("flush_pop", 4, 32'(m_data[4]), 32'h0AA);
        adv();
        flush[4] = 1'b0;
        look();
        chk("post_flush_tvalid", 4, 32'(m_valid[4]), 0);
        adv();
        s_valid[4] = 1'b0;
        tick();
        tick();
        m_ready[4] = 1'b0;

        // DEPTH=1 throughput, both ready modes.
        popcnt[2] = 0;
        popcnt[3] = 0;
        for (int g = 2; g < 4; g++) begin
            s_valid[g] = 1'b1;
            m_ready[g] = 1'b1;
            s_data[g]  = 8'h40;
        end
        for (int i = 0; i < 20; i++) begin
            look();
            adv();
            for (int g = 2; g < 4; g++)
                if (psh[g]) s_data[g] = s_data[g] + 8'd1;
        end
        chk("d1_pass_pops", 2, popcnt[2], 19);
        chk("d1_nopass_pops", 3, popcnt[3], 10);
        s_valid[2] = 1'b0;
        s_valid[3] = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Random traffic; DEPTH=3 instance carries the sequence 0..9.
        seq1 = 0;
        popcnt[1] = 0;
        for (int g = 0; g < N; g++) psh[g] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            for (int g = 0; g < N; g++) begin
                m_ready[g] = 1'($urandom_range(0, 1));
                if (g != 1) flush[g] = ($urandom_range(0, 15) == 0);
                if (!s_valid[g] || psh[g]) begin
                    if (g == 1) begin
                        s_valid[g] = (seq1 < 10) && ($urandom_range(0, 1) == 1);
                        s_data[g]  = 8'(seq1);
                    end else begin
                        s_valid[g] = 1'($urandom_range(0, 1));
                        s_data[g]  = 8'($urandom);
                    end
                end
            end
            look();
            adv();
            if (psh[1]) seq1++;
        end
        for (int g = 0; g < N; g++) begin
            m_ready[g] = 1'b1;
            flush[g]   = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            look();
            adv();
            if (psh[1]) seq1++;
            for (int g = 0; g < N; g++)
                if (psh[g]) s_valid[g] = 1'b0;
        end
        chk("d3_accepted", 1, seq1, 10);
        chk("d3_popped", 1, popcnt[1], 10);

        // Async reset between clock edges, mid-burst.
        for (int g = 0; g < N; g++) m_ready[g] = 1'b0;
        s_valid[0] = 1'b1;
        s_valid[4] = 1'b1;
        s_data[0]  = 8'h77;
        s_data[4]  = 8'h66;
        tick();
        tick();
        #2 rst = 1'b1;
        #1 chk_rst_outputs("midrst");
        for (int g = 0; g < N; g++) begin
            q[g].delete();
            s_valid[g] = 1'b0;
            psh[g]     = 1'b0;
        end
        tick();
        rst = 1'b0;
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h5A;
        m_ready[0] = 1'b1;
        tick();
        s_valid[0] = 1'b0;
        look();
        chk("post_rst_valid", 0, 32'(m_valid[0]), 1);
        chk("post_rst_data", 0, 32'(m_data[0]), 32'h05A);
        adv();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_buffer.md
# axis_buffer

Parametrised AXI Stream buffer, successor to the single-stage register slice. Depth-configurable register storage (1..N entries) between an `axis_if` subordinate and manager, with a selectable ready mode and a synchronous flush that implements slice invalidation. It is used on pipeline boundaries where a registered `tready` or several entries of elasticity are needed, e.g. fetch to decode.

## Interface
- `DEPTH`, 2: number of storage entries, must be ≥ 1.
- `READY_PASS`, 0:
  - 1: `axis_sif.tready = !full || axis_mif.tready` (combinational path from downstream).
  - 0: `axis_sif.tready = !full` (no combinational path from downstream).
- `TDATA_WIDTH`: taken from `axis_mif.TDATA_WIDTH`. Elaboration fatal if it is 0 or differs from `axis_sif.TDATA_WIDTH`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `axis_mif`  modport m  —  output stream (`tvalid`, `tdata` out; `tready` in).
- `axis_sif`  modport s  —  input stream (`tvalid`, `tdata` in; `tready` out).
- `flush`  in  1  synchronous discard of all stored beats.
- `level`  out  $clog2(DEPTH+1)  occupancy; present only with `AXIS_BUFFER_LEVEL_EN`.

## Operation
- Storage is a circular buffer of DEPTH entries.
  - Write pointer and read pointer are each max(1, $clog2(DEPTH)) bits.
  - Count is $clog2(DEPTH+1) bits.
  - Full when count == DEPTH; empty when count == 0.
- Pointers wrap explicitly from DEPTH-1 to 0. DEPTH need not be a power of two.
- `axis_mif.tvalid = (count != 0)`. `axis_mif.tdata = mem[rd_ptr]`. tdata is undefined-by-contract while tvalid = 0.
- push = `axis_sif.tvalid && axis_sif.tready`. It writes `mem[wr_ptr]` and advances wr_ptr.
- pop = `axis_mif.tvalid && axis_mif.tready`. It advances rd_ptr.
- Count update: push only: +1; pop only: -1; both: unchanged.
- Push and pop in the same cycle when full:
  - Legal only with READY_PASS = 1.
  - Write lands in the slot being vacated (wr_ptr == rd_ptr).
  - The new beat appears on the output after the older beats, per FIFO order.
- Flush:
  - `axis_sif.tready` is forced 0 during the flush cycle, so no input beat is accepted and none is silently dropped.
  - A pop in the flush cycle completes normally.
  - Next cycle: count = 0, both pointers = 0.
  - Memory contents are not cleared.
- Ordering is strict FIFO. No beat is duplicated or reordered.
- Reset (`rst` = 1, asynchronous), as long as `rst` is held:
  - count, pointers and all memory entries are 0.
  - `axis_mif.tvalid` = 0, `axis_mif.tdata` = 0.
  - `axis_sif.tready` = 0.
  - `level` = 0.
- Reset mid-stream drops every stored beat with no partial state.

## Timing
- Latency: an accepted beat is visible on `axis_mif` the cycle after acceptance, when the buffer was empty.
- No combinational path from `axis_sif` to `axis_mif`.
- `axis_mif.tvalid` and `tdata` are register or mux outputs only.
- Throughput:
  - 1 beat/cycle when DEPTH ≥ 2, or when READY_PASS = 1.
  - DEPTH = 1 with READY_PASS = 0 gives 1 beat per 2 cycles under continuous traffic. This is allowed but documented.
- DEPTH = 1 with READY_PASS = 1 is cycle-identical to the legacy register slice, apart from the active-high reset.
- `axis_sif.tready` after a pop with READY_PASS = 0: rises the cycle after the pop that leaves the buffer non-full.
- Handshake rules: AXI Stream. tvalid, once asserted, is not withdrawn until the handshake. tdata is stable while tvalid && !tready.

## Configuration
- `AXIS_BUFFER_LEVEL_EN` defined:
  - Adds the `level` output port, equal to the registered count.
  - Adds a simulation-only overflow/underflow assertion on count.
- Undefined: no `level` port, and count stays internal. Stream behaviour is identical either way.

## Structure
- Shared package `axis_pkg`:
  - `AXIS_BUFFER_DEPTH_DEFAULT` = 2.
  - Function `axis_ptr_width(depth)`, returning max(1, $clog2(depth)), reused by other stream blocks.
- One sub-module: `axis_buffer_mem`.
  - DEPTH × TDATA_WIDTH register array with asynchronous clear on `rst`.
  - One write port (enable, address, data) and one combinational read port.
- Pointer/count control and ready generation live in `axis_buffer`.

## Test plan
- DEPTH=4, READY_PASS=0: push 0x11,0x22,0x33,0x44 with `axis_mif.tready` = 0 → `axis_sif.tready` falls after the 4th beat. Releasing tready then pops 0x11..0x44 in order on 4 consecutive cycles.
- DEPTH=3: stream 10 beats 0..9 with random `axis_mif.tready` → output order 0..9, nothing lost, pointers wrap 2→0 at least three times.
- DEPTH=1, READY_PASS=1, both sides always ready → 1 beat/cycle, 1-cycle latency. With READY_PASS=0, same stimulus gives 1 beat per 2 cycles.
- DEPTH=2 holding 0xAA,0xBB, `flush` asserted while `axis_mif.tready` = 1 → 0xAA is popped, `axis_sif.tready` = 0 that cycle, next cycle tvalid = 0 and `level` = 0.
- Full buffer (DEPTH=2, READY_PASS=1), simultaneous push 0xCC and pop → count stays 2, next outputs are 0xBB then 0xCC.
- Assert `rst` asynchronously mid-burst, between clock edges → tvalid, tready, tdata and level are 0 immediately. After release, the first new beat is output unaltered.
